// File: rtl/generic_mem_requester.sv
// Request/response front end for a single-port generic_memory: credit-based request
// acceptance, a read-latency flag pipeline and a response FIFO. Optional macro
// GENERIC_MEM_REQ_WACK_EN makes writes return the overwritten data as a response.
module generic_mem_requester #(
  parameter type T            = logic [31:0],
  parameter int  ADDR_W       = 8,
  parameter int  READ_LATENCY = 1,
  parameter int  RSP_DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [$bits(T)-1:0] req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [$bits(T)-1:0] rsp_rdata,
`ifdef GENERIC_MEM_REQ_WACK_EN
  output logic                rsp_is_write,
`endif
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [$bits(T)-1:0] mem_write_data,
  output logic                mem_write_en,
  input  logic [$bits(T)-1:0] mem_read_data
);

  localparam int DW    = $bits(T);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(RSP_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);

`ifdef GENERIC_MEM_REQ_WACK_EN
  localparam bit WACK_EN = 1'b1;
`else
  localparam bit WACK_EN = 1'b0;
`endif

  logic                    accept;
  logic                    credit_take;
  logic                    track_in;
  logic                    push_en;
  logic                    pop;

  logic [CNT_W-1:0]        count_reg;
  logic [CNT_W-1:0]        count_next;
  logic [CNT_W-1:0]        fifo_cnt_reg;
  logic [CNT_W-1:0]        fifo_cnt_next;
  logic [PTR_W-1:0]        wr_ptr_reg;
  logic [PTR_W-1:0]        wr_ptr_next;
  logic [PTR_W-1:0]        rd_ptr_reg;
  logic [PTR_W-1:0]        rd_ptr_next;
  logic [READ_LATENCY-1:0] flag_reg;
  logic [DW-1:0]           fifo_mem [RSP_DEPTH];

  // Gating with rst_n keeps req_ready low while reset is held yet allows an
  // accept on the very first edge after release.
  assign req_ready    = rst_n && (count_reg < DEPTH_C);
  assign accept       = req_valid && req_ready;
  assign credit_take  = accept && (WACK_EN || !req_write);
  assign track_in     = credit_take;

  assign mem_addr       = req_addr;
  assign mem_write_data = req_wdata;
  assign mem_write_en   = accept && req_write;

  assign push_en   = flag_reg[READ_LATENCY-1];
  assign rsp_valid = (fifo_cnt_reg != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_rdata = rsp_valid ? fifo_mem[rd_ptr_reg] : '0;

  genvar gi;
  generate
    for (gi = 0; gi < READ_LATENCY; gi++) begin : g_stage
      logic stage_in;
      if (gi == 0) begin : g_first
        assign stage_in = track_in;
      end else begin : g_next
        assign stage_in = flag_reg[gi-1];
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          flag_reg[gi] <= 1'b0;
        end else begin
          flag_reg[gi] <= stage_in;
        end
      end
    end
  endgenerate

`ifdef GENERIC_MEM_REQ_WACK_EN
  logic [READ_LATENCY-1:0] wflag_reg;
  logic                    fifo_wr_mem [RSP_DEPTH];

  generate
    for (gi = 0; gi < READ_LATENCY; gi++) begin : g_wstage
      logic wstage_in;
      if (gi == 0) begin : g_first
        assign wstage_in = credit_take && req_write;
      end else begin : g_next
        assign wstage_in = wflag_reg[gi-1];
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wflag_reg[gi] <= 1'b0;
        end else begin
          wflag_reg[gi] <= wstage_in;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (push_en) begin
      fifo_wr_mem[wr_ptr_reg] <= wflag_reg[READ_LATENCY-1];
    end
  end

  assign rsp_is_write = rsp_valid ? fifo_wr_mem[rd_ptr_reg] : 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push_en) begin
      fifo_mem[wr_ptr_reg] <= mem_read_data;
    end
  end

  // count covers reads in flight plus buffered entries, so the FIFO can never overflow.
  always_comb begin
    count_next = count_reg;
    case ({credit_take, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    fifo_cnt_next = fifo_cnt_reg;
    case ({push_en, pop})
      2'b10:   fifo_cnt_next = fifo_cnt_reg + 1'b1;
      2'b01:   fifo_cnt_next = fifo_cnt_reg - 1'b1;
      default: fifo_cnt_next = fifo_cnt_reg;
    endcase
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (push_en) begin
      wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg    <= '0;
      fifo_cnt_reg <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
    end else begin
      count_reg    <= count_next;
      fifo_cnt_reg <= fifo_cnt_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
    end
  end

endmodule

// File: doc/generic_mem_requester.md
# generic_mem_requester

Initiator-side front end for the single-port `generic_memory` block. It accepts read/write requests over a valid/ready handshake and drives the memory's address, write-data and write-enable pins. It also absorbs the memory's fixed read latency by tracking in-flight reads and buffering returned data in a response FIFO with its own valid/ready handshake. It sits between any client datapath and one `generic_memory` instance of the same element type `T`.

## Interface
- `T`, `logic [31:0]`: element type; must match the attached memory's `T`.
- `ADDR_W`, 8: address width; must match the memory.
- `READ_LATENCY`, 1: cycles from the memory sampling `mem_addr` to `mem_read_data` being valid; legal range 1..4.
- `RSP_DEPTH`, 4: response credit count (FIFO depth); legal range 1..16. Back-to-back full throughput requires `RSP_DEPTH >= READ_LATENCY+2`.
- `clk` in 1: single clock; all state is updated on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request can be accepted.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in `ADDR_W`: request address.
- `req_wdata` in `$bits(T)`: write data.
- `rsp_valid` out 1: response data present.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_rdata` out `$bits(T)`: response data.
- `rsp_is_write` out 1: present only with `GENERIC_MEM_REQ_WACK_EN`; 1 = this response belongs to a write.
- `mem_addr` out `ADDR_W`: to memory `addr`.
- `mem_write_data` out `$bits(T)`: to memory `write_data`.
- `mem_write_en` out 1: to memory `write_en`.
- `mem_read_data` in `$bits(T)`: from memory `read_data`.

## Operation
- **Accept:** a request is accepted when `req_valid && req_ready` is high at a rising edge.
- **Ready rule:** `req_ready = (count < RSP_DEPTH)`.
  - `count` is a register: reads in flight plus FIFO entries. It counts credit-consuming requests only (see Configuration).
  - `req_ready` depends on no input in the same cycle. It therefore does not see a same-cycle pop.
- **Memory drive (combinational pass-through):**
  - `mem_addr = req_addr` and `mem_write_data = req_wdata`.
  - `mem_write_en = req_valid && req_ready && req_write`.
  - The memory never sees a write that was not accepted.
- **Read tracking:**
  - Each accepted read pushes a 1 into a `READ_LATENCY`-stage flag shift register; other cycles push 0.
  - When the last stage is 1, `mem_read_data` is written into the FIFO at that edge.
- **FIFO:**
  - Circular buffer with `RSP_DEPTH` entries; read and write pointers wrap modulo `RSP_DEPTH`.
  - `rsp_valid` = FIFO not empty; `rsp_rdata` = head entry.
  - A pop occurs on `rsp_valid && rsp_ready`.
- **Count update:** `count` += 1 on an accepted credit-consuming request and −1 on a pop; both in the same cycle leaves it unchanged.
- **Overflow:** cannot happen, because the credits bound occupancy. The bench asserts that a push into a full FIFO never occurs.
- **Ordering:** responses return strictly in request order.
- **Read-during-write:** a read issued the cycle after a write to the same address returns the new data.
- **Reset:**
  - While `rst_n` = 0: `req_ready` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `count` = 0, shift register = 0, pointers = 0.
  - Reset asserted mid-operation discards in-flight reads and buffered responses.
  - The first accept can occur on the first edge after deassertion.

## Timing
- **Memory pins:** for a request accepted in cycle N, the memory pins carry it in cycle N, and the memory samples it at the end of N.
- **Data capture:** read data is captured into the FIFO at the end of cycle N+READ_LATENCY.
- **Response:** `rsp_valid` rises in cycle N+READ_LATENCY+1; request-to-response latency is READ_LATENCY+1 cycles.
- **Pop:** a popped entry disappears the next cycle. The following entry, if any, is presented without a bubble.
- **Throughput:** with `RSP_DEPTH >= READ_LATENCY+2` and `rsp_ready` held high, one request per cycle is sustained indefinitely.
- **Back-pressure:** with `rsp_ready` low, exactly `RSP_DEPTH` credit-consuming requests are accepted, then `req_ready` drops.

## Configuration
- **`GENERIC_MEM_REQ_WACK_EN` undefined:**
  - Writes consume no credit and produce no response.
  - Writes still stall when `req_ready` is 0.
  - The `rsp_is_write` port does not exist.
- **`GENERIC_MEM_REQ_WACK_EN` defined:**
  - Writes consume a credit and travel the read pipeline.
  - A write's response carries `rsp_is_write` = 1 and `rsp_rdata` = the address's contents before the write (the memory returns old data on a write cycle), giving swap semantics.
  - Reads carry `rsp_is_write` = 0.

## Test plan
- **Reset:** hold `rst_n` = 0 for 3 cycles with `req_valid` = 1 → `req_ready` = 0, `rsp_valid` = 0, `mem_write_en` = 0 throughout.
- **Write then read:** write 0xDEADBEEF to addr 0x10, then read 0x10 with `READ_LATENCY` = 1 → `rsp_valid` rises 2 cycles after the read accept with `rsp_rdata` = 0xDEADBEEF.
- **Streaming:** 64 back-to-back reads of addr 0..63 (preloaded with addr×3), `rsp_ready` = 1, `RSP_DEPTH` = 4 → `req_ready` never drops, responses 0,3,…,189 arrive in order on consecutive cycles.
- **Back-pressure:** `rsp_ready` = 0 while issuing 6 reads → exactly 4 are accepted, then `req_ready` = 0. Raising `rsp_ready` drains 4 in order, then the remaining 2 are accepted.
- **Reset mid-stream:** assert `rst_n` low with 2 reads in flight and 2 buffered → no `rsp_valid` after deassertion until new reads are issued.
- **Write acknowledge:** with `GENERIC_MEM_REQ_WACK_EN`, write 0x5 over 0x7 at addr 0x20 → response `rsp_is_write` = 1, `rsp_rdata` = 0x7; a following read returns 0x5 with `rsp_is_write` = 0.
